jtgng_chrom_server: RTL and testbench
=====================================

Name: jtgng_chrom_server

Overview:
- Serves the character layer's tile ROM fetches: it watches the 13-bit char ROM address and returns the 16-bit pixel word (chrom_data).
- It sits between the character tile generator and the shared SDRAM arbiter.
- It detects new addresses, issues one SDRAM read per change, and holds the returned word stable until the next word is delivered.
- It also reports deadline misses, so video glitches caused by SDRAM contention can be diagnosed.

Parameters:
- CHAR_OFFSET, 22'h0, SDRAM word base address of the char ROM region.
- DEADLINE, 6'd31, clk cycles allowed from address change to data delivery (8 pixels at 6 MHz on a 24 MHz clk = 32 clk, minus 1).

Ports:
- clk  in  1  24 MHz system clock
- rst  in  1  synchronous reset, active-high
- char_addr  in  13  word address from the char layer; may change on any cen6 cycle
- chrom_data  out  16  pixel word for the last completed char_addr
- chrom_ok  out  1  high when chrom_data corresponds to the current char_addr
- sdram_req  out  1  read request to the SDRAM arbiter
- sdram_addr  out  22  CHAR_OFFSET + char_addr, zero-extended; 22-bit sum, wraps modulo 2^22
- sdram_ack  in  1  one-cycle pulse: arbiter accepted the request
- data_rdy  in  1  one-cycle pulse: sdram_data valid
- sdram_data  in  16  read data
- late  out  1  one-cycle pulse when a fetch exceeds DEADLINE

Behaviour:
- Reset: chrom_data=0, chrom_ok=0, sdram_req=0, sdram_addr=0, late=0, state=IDLE, the last-address register is marked invalid, and the age counter is 0. Reset mid-fetch abandons the fetch; a data_rdy arriving after reset is ignored.
- New-address detect: register char_addr every clk into last_addr. A fetch is needed when char_addr differs from the address of the word held, or when the held word is invalid.
- IDLE: if a fetch is needed, latch req_addr=char_addr, drive sdram_addr, set sdram_req=1, clear the age counter, clear chrom_ok, and go to REQ. Otherwise stay in IDLE with chrom_ok=1 (once valid).
- REQ: hold sdram_req=1 and sdram_addr stable. On sdram_ack, drop sdram_req on the next edge and go to WAIT.
- ack and data_rdy in the same cycle: go straight to delivery (same as WAIT+data_rdy).
- WAIT: on data_rdy, capture sdram_data into chrom_data, record held_addr=req_addr, and return to IDLE.
  - chrom_ok=1 on the next cycle only if char_addr still equals req_addr; otherwise a new fetch starts immediately from IDLE.
- Address change while in REQ: req_addr is not updated and the request continues. The word is captured on completion, then the mismatch triggers a refetch. sdram_addr never changes while sdram_req=1.
- Latency: 1 clk from address change to sdram_req rise; 1 clk from data_rdy to chrom_data update.
- Age counter: 6 bits, counts every clk while in REQ or WAIT and saturates at 63.
  - late pulses exactly once per fetch, on the cycle the counter equals DEADLINE+1.
  - If data arrives at count <= DEADLINE, no pulse.
- chrom_data never changes except on data_rdy capture or reset. It is never cleared by an address change, so the layer shows stale pixels rather than garbage.
- Stray data_rdy in IDLE or REQ (before ack): ignored.

Optional Feature:
- Macro JTGNG_CHROM_CACHE_EN.
- With the macro: a 16-entry direct-mapped cache indexed by char_addr[3:0], tag char_addr[12:4] plus a valid bit; all entries are invalidated by rst.
  - Hit in IDLE: chrom_data is loaded from the cache on the next clk, chrom_ok=1, and no SDRAM request is made.
  - Miss: normal fetch, and the cache entry is filled on data_rdy.
  - The late counter does not run on hits.
- Without the macro: no cache storage; every address change causes an SDRAM fetch.

Test Plan:
- Reset then char_addr=13'h0123, CHAR_OFFSET=22'h10000: sdram_req rises 1 clk later with sdram_addr=22'h10123. Ack after 3 clk, data_rdy with 16'hA55A after 5 more: chrom_data=16'hA55A and chrom_ok=1 one clk later; late never pulses.
- Hold the arbiter ack off for 40 clk: late pulses once, at the cycle age=32. The data is still captured on data_rdy and chrom_ok then rises.
- Change char_addr from 13'h0010 to 13'h0011 while in WAIT:
  - sdram_addr stays at 0010 and that word is captured;
  - chrom_ok stays 0;
  - a second request for 0011 issues the cycle after capture.
- Assert rst while in WAIT, then pulse data_rdy with 16'hFFFF: chrom_data stays 0, state is IDLE, sdram_req=0.
- Same-cycle sdram_ack and data_rdy with 16'h1234: chrom_data=16'h1234 next clk, and no hang in WAIT.
- With JTGNG_CHROM_CACHE_EN, fetch 13'h0005 then 13'h0006 then 13'h0005 again:
  - third access gives no sdram_req and chrom_ok=1 after 1 clk with the first word.
  - Then access 13'h0015 (same index, different tag): a fetch is issued.

Source files
------------

// File: rtl/jtgng_chrom_server_if.sv
// jtgng_chrom_server_if: char layer request side and SDRAM arbiter side of the char ROM server.
interface jtgng_chrom_server_if;
   logic [12:0] char_addr;
   logic [15:0] chrom_data;
   logic        chrom_ok;
   logic        sdram_req;
   logic [21:0] sdram_addr;
   logic        sdram_ack;
   logic        data_rdy;
   logic [15:0] sdram_data;
   logic        late;
   modport master(
      input  char_addr, sdram_ack, data_rdy, sdram_data,
      output chrom_data, chrom_ok, sdram_req, sdram_addr, late
   );
   modport slave(
      output char_addr, sdram_ack, data_rdy, sdram_data,
      input  chrom_data, chrom_ok, sdram_req, sdram_addr, late
   );
endinterface

// File: rtl/jtgng_chrom_server.sv
// jtgng_chrom_server: fetches char tile words from SDRAM on address change and flags deadline misses.
// Define JTGNG_CHROM_CACHE_EN to add a 16-entry direct-mapped word cache in front of SDRAM.
module jtgng_chrom_server #(
   parameter logic [21:0] CHAR_OFFSET = 22'h0,
   parameter logic [5:0]  DEADLINE    = 6'd31
) (
   input logic                  clk,
   input logic                  rst,
   jtgng_chrom_server_if.master bus
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   state_t      state, state_nx;
   logic [12:0] req_addr, held_addr;
   logic        held_valid;
   logic [5:0]  age;
   logic        need, hit, busy, start, lookup, capture;
   logic [15:0] hit_data;

   assign need     = !held_valid || bus.char_addr != held_addr;
   assign busy     = state != IDLE;
   assign bus.late = busy && age == DEADLINE + 6'd1;

`ifdef JTGNG_CHROM_CACHE_EN
   logic [8:0]  tags  [16];
   logic [15:0] words [16];
   logic [15:0] valid;
   assign hit      = valid[bus.char_addr[3:0]] && tags[bus.char_addr[3:0]] == bus.char_addr[12:4];
   assign hit_data = words[bus.char_addr[3:0]];
   always_ff @(posedge clk) begin
      if (rst) valid <= '0;
      else if (capture) valid[req_addr[3:0]] <= 1'b1;
   end
   always_ff @(posedge clk) begin
      if (capture) begin
         tags[req_addr[3:0]]  <= req_addr[12:4];
         words[req_addr[3:0]] <= bus.sdram_data;
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_data = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         req_addr       <= '0;
         held_addr      <= '0;
         held_valid     <= 1'b0;
         age            <= '0;
         bus.chrom_data <= '0;
         bus.chrom_ok   <= 1'b0;
         bus.sdram_req  <= 1'b0;
         bus.sdram_addr <= '0;
      end else begin
         state         <= state_nx;
         age           <= start ? 6'd0 : busy && age != 6'd63 ? age + 6'd1 : age;
         bus.sdram_req <= state_nx == REQ;
         bus.chrom_ok  <= capture ? bus.char_addr == req_addr : state == IDLE && !start;
         if (start) begin
            req_addr       <= bus.char_addr;
            bus.sdram_addr <= CHAR_OFFSET + {9'd0, bus.char_addr};
         end
         // the held word is only replaced by a completed fetch or a cache hit
         if (capture || lookup) begin
            bus.chrom_data <= capture ? bus.sdram_data : hit_data;
            held_addr      <= capture ? req_addr : bus.char_addr;
            held_valid     <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = capture ? IDLE :
                 start ? REQ :
                 state == REQ && bus.sdram_ack ? WAIT : state;
   end

   always_comb begin
      start   = state == IDLE && need && !hit;
      lookup  = state == IDLE && need && hit;
      capture = (state == WAIT || (state == REQ && bus.sdram_ack)) && bus.data_rdy;
   end
endmodule

// File: tb/tb_jtgng_chrom_server.sv
// tb_jtgng_chrom_server: directed stimulus against a fetch-level model of the char ROM server.
module tb_jtgng_chrom_server;
   localparam logic [21:0] OFF = 22'h10000;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0, errors = 0, cyc = 0, lates = 0, late_cyc = 0, req_cyc = 0, lates0 = 0;

   jtgng_chrom_server_if bus();
   jtgng_chrom_server #(.CHAR_OFFSET(OFF), .DEADLINE(6'd31)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [15:0] m_data = '0;
   logic        m_ok = 1'b0, m_req = 1'b0, m_busy = 1'b0, m_acked = 1'b0, m_hv = 1'b0;
   logic        m_hit, m_deliver;
   logic [21:0] m_addr = '0;
   logic [12:0] m_pend = '0, m_held = '0, m_ca;
   int          m_age = 0;
`ifdef JTGNG_CHROM_CACHE_EN
   logic [15:0] c_word [16];
   logic [8:0]  c_tag  [16];
   logic        c_v    [16];
`endif

   // outputs are compared against the model, then the model absorbs the inputs the next edge will see
   always @(negedge clk) begin
      chk("chrom_data", bus.chrom_data, m_data);
      chk("chrom_ok", bus.chrom_ok, m_ok);
      chk("sdram_req", bus.sdram_req, m_req);
      chk("sdram_addr", bus.sdram_addr, m_addr);
      chk("late", bus.late, m_busy && m_age == 32);
      if (bus.late) begin
         lates++;
         late_cyc = cyc;
      end
      m_ca = bus.char_addr;
      if (rst) begin
         m_data = '0; m_ok = 0; m_req = 0; m_addr = '0; m_busy = 0; m_hv = 0; m_age = 0;
`ifdef JTGNG_CHROM_CACHE_EN
         for (int i = 0; i < 16; i++) c_v[i] = 0;
`endif
      end else if (!m_busy) begin
         if (!m_hv || m_ca != m_held) begin
            m_hit = 0;
`ifdef JTGNG_CHROM_CACHE_EN
            m_hit = c_v[m_ca[3:0]] && c_tag[m_ca[3:0]] == m_ca[12:4];
`endif
            if (m_hit) begin
`ifdef JTGNG_CHROM_CACHE_EN
               m_data = c_word[m_ca[3:0]];
`endif
               m_held = m_ca; m_hv = 1; m_ok = 1;
            end else begin
               m_busy = 1; m_acked = 0; m_pend = m_ca; m_req = 1;
               m_addr = OFF + 22'(m_ca); m_age = 0; m_ok = 0;
            end
         end else m_ok = 1;
      end else begin
         m_deliver = bus.data_rdy && (m_acked || bus.sdram_ack);
         if (bus.sdram_ack && !m_acked) begin
            m_acked = 1;
            m_req = 0;
         end
         m_age = m_age < 63 ? m_age + 1 : 63;
         if (m_deliver) begin
            m_data = bus.sdram_data; m_held = m_pend; m_hv = 1; m_busy = 0;
            m_ok = m_ca == m_pend;
`ifdef JTGNG_CHROM_CACHE_EN
            c_word[m_pend[3:0]] = bus.sdram_data;
            c_tag[m_pend[3:0]] = m_pend[12:4];
            c_v[m_pend[3:0]] = 1;
`endif
         end
      end
   end

   task automatic fetch(input logic [12:0] a, input logic [15:0] d);
      bus.char_addr = a;
      for (int i = 0; i < 20 && !bus.sdram_req; i++) step(1);
      chk("fetch_req", bus.sdram_req, 1);
      bus.sdram_ack = 1; step(1); bus.sdram_ack = 0; step(1);
      bus.data_rdy = 1; bus.sdram_data = d; step(1); bus.data_rdy = 0;
      chk("fetch_data", bus.chrom_data, d);
   endtask

   initial begin
      bus.char_addr = 13'h0123; bus.sdram_ack = 0; bus.data_rdy = 0; bus.sdram_data = '0;
      step(2);
      chk("rst_data", bus.chrom_data, 0);
      chk("rst_ok", bus.chrom_ok, 0);
      chk("rst_req", bus.sdram_req, 0);
      chk("rst_addr", bus.sdram_addr, 0);
      chk("rst_late", bus.late, 0);
      rst = 0;
      step(1);
      chk("t1_req", bus.sdram_req, 1);
      chk("t1_addr", bus.sdram_addr, 22'h10123);
      step(3);
      bus.sdram_ack = 1; step(1); bus.sdram_ack = 0;
      chk("t1_req_drop", bus.sdram_req, 0);
      step(4);
      bus.data_rdy = 1; bus.sdram_data = 16'hA55A; step(1); bus.data_rdy = 0;
      chk("t1_data", bus.chrom_data, 16'hA55A);
      chk("t1_ok", bus.chrom_ok, 1);
      chk("t1_no_late", lates, 0);

      lates0 = lates;
      bus.char_addr = 13'h0200; step(1);
      req_cyc = cyc;
      chk("t2_req", bus.sdram_req, 1);
      step(40);
      bus.sdram_ack = 1; step(1); bus.sdram_ack = 0; step(2);
      bus.data_rdy = 1; bus.sdram_data = 16'h0BEE; step(1); bus.data_rdy = 0;
      chk("t2_data", bus.chrom_data, 16'h0BEE);
      chk("t2_ok", bus.chrom_ok, 1);
      chk("t2_late_once", lates - lates0, 1);
      chk("t2_late_age", late_cyc - req_cyc, 32);

      bus.char_addr = 13'h0010; step(1);
      bus.sdram_ack = 1; step(1); bus.sdram_ack = 0; step(1);
      bus.char_addr = 13'h0011; step(2);
      chk("t3_addr_hold", bus.sdram_addr, 22'h10010);
      chk("t3_ok_low", bus.chrom_ok, 0);
      bus.data_rdy = 1; bus.sdram_data = 16'h5A5A; step(1); bus.data_rdy = 0;
      chk("t3_data", bus.chrom_data, 16'h5A5A);
      chk("t3_ok_stale", bus.chrom_ok, 0);
      step(1);
      chk("t3_refetch", bus.sdram_req, 1);
      chk("t3_refetch_addr", bus.sdram_addr, 22'h10011);

      step(1);
      bus.sdram_ack = 1; bus.data_rdy = 1; bus.sdram_data = 16'h1234; step(1);
      bus.sdram_ack = 0; bus.data_rdy = 0;
      chk("t5_data", bus.chrom_data, 16'h1234);
      chk("t5_ok", bus.chrom_ok, 1);
      step(1);
      chk("t5_no_hang", bus.sdram_req, 0);
      chk("t5_ok_hold", bus.chrom_ok, 1);

      bus.char_addr = 13'h0400; step(1);
      bus.sdram_ack = 1; step(1); bus.sdram_ack = 0; step(2);
      rst = 1; step(1); rst = 0;
      bus.data_rdy = 1; bus.sdram_data = 16'hFFFF;
      chk("t4_req", bus.sdram_req, 0);
      chk("t4_data", bus.chrom_data, 0);
      step(1); bus.data_rdy = 0;
      chk("t4_data_ignored", bus.chrom_data, 0);
      fetch(13'h0400, 16'h4444);

      fetch(13'h0005, 16'h0505);
      fetch(13'h0006, 16'h0606);
      bus.char_addr = 13'h0005; step(1);
`ifdef JTGNG_CHROM_CACHE_EN
      chk("c_hit_req", bus.sdram_req, 0);
      chk("c_hit_ok", bus.chrom_ok, 1);
      chk("c_hit_data", bus.chrom_data, 16'h0505);
      bus.char_addr = 13'h0015; step(1);
      chk("c_miss_req", bus.sdram_req, 1);
      chk("c_miss_addr", bus.sdram_addr, 22'h10015);
      fetch(13'h0015, 16'h1515);
`else
      chk("nc_req", bus.sdram_req, 1);
      fetch(13'h0005, 16'h0505);
`endif
      step(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
